// File: rtl/sprite_rom_scheduler_pkg.sv
// Shared sprite ROM geometry, derived address widths and the address packing
// helper used by the scheduler and the per-sprite line renderers.
package sprite_pkg;

  localparam int SPR_W     = 16;
  localparam int SPR_H     = 16;
  localparam int SPR_N     = 4;
  localparam int SPR_PW    = 4;

  localparam int COL_W     = $clog2(SPR_W);
  localparam int ROW_W     = $clog2(SPR_H);
  localparam int SPR_IDX_W = $clog2(SPR_N);
  localparam int ROM_AW    = SPR_IDX_W + ROW_W + COL_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sched_state_e;

  // ROM word address: {sprite, row, col}, column in the LSBs.
  function automatic logic [ROM_AW-1:0] spr_addr(
    input logic [SPR_IDX_W-1:0] sprite,
    input logic [ROW_W-1:0]     row,
    input logic [COL_W-1:0]     col
  );
    return {sprite, row, col};
  endfunction

endpackage

// File: rtl/sprite_rom_scheduler_if.sv
// Bundle between the sprite line renderers, the scheduler and the sprite ROM.
// The scheduler takes the slave view; renderers/ROM side take the master view.
interface sprite_rom_scheduler_if
  import sprite_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int NSPRITES = SPR_N,
  parameter int WIDTH    = SPR_W,
  parameter int HEIGHT   = SPR_H,
  parameter int PW       = SPR_PW
);
  localparam int SW = $clog2(NSPRITES);
  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*SW-1:0] req_sprite;
  logic [NREQ*RW-1:0] req_row;
  logic [NREQ-1:0]    gnt;
  logic [SW+RW+CW-1:0] rom_add;
  logic [PW-1:0]      rom_pixel;
  logic               pix_valid;
  logic [PW-1:0]      pix_data;
  logic [CW-1:0]      pix_col;
  logic [OW-1:0]      pix_owner;
  logic               pix_last;
  logic               busy;

  modport slave (
    input  req, req_sprite, req_row, rom_pixel,
    output gnt, rom_add, pix_valid, pix_data, pix_col, pix_owner, pix_last, busy
  );

  modport master (
    output req, req_sprite, req_row, rom_pixel,
    input  gnt, rom_add, pix_valid, pix_data, pix_col, pix_owner, pix_last, busy
  );

endinterface

// File: rtl/sprite_rom_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after the last owner,
// wrapping modulo NREQ. Nothing is granted while i_en is low.
module rr_arbiter
  import sprite_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OW   = $clog2(NREQ)
)(
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  input  logic [OW-1:0]   i_last_owner,
  output logic [NREQ-1:0] o_gnt,
  output logic [OW-1:0]   o_idx,
  output logic            o_valid
);

  // Scan from last_owner+1 around the ring, keeping the first hit only.
  always_comb begin : p_pick
    logic [OW-1:0] w_idx;
    logic          w_hit;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    w_hit   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx        = OW'((int'(i_last_owner) + k) % NREQ);
      w_hit        = i_en & ~o_valid & i_req[w_idx];
      o_gnt[w_idx] = o_gnt[w_idx] | w_hit;
      o_idx        = w_hit ? w_idx : o_idx;
      o_valid      = o_valid | w_hit;
    end
  end

endmodule

// File: rtl/sprite_rom_scheduler.sv
// Row-granular round-robin scheduler sharing the single-port sprite ROM between
// sprite engines; streams each 16-pixel row back tagged with owner and column.
module sprite_rom_scheduler
  import sprite_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int NSPRITES = SPR_N,
  parameter int WIDTH    = SPR_W,
  parameter int HEIGHT   = SPR_H,
  parameter int PW       = SPR_PW
)(
  input  logic                   clk,
  input  logic                   rstn,
  sprite_rom_scheduler_if.slave  bus
);

  localparam int SW = $clog2(NSPRITES);
  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam int OW = $clog2(NREQ);
  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [OW-1:0] OWNER_INIT = OW'(NREQ - 1);

  sched_state_e    r_state;
  sched_state_e    w_next_state;
  logic [SW-1:0]   r_sprite;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [OW-1:0]   r_owner;
  logic [NREQ-1:0] r_gnt;
  logic            r_pix_valid;
  logic            r_pix_last;
  logic [CW-1:0]   r_pix_col;
  logic [OW-1:0]   r_pix_owner;

  logic            w_busy;
  logic            w_arb_en;
  logic            w_col_last;
  logic [NREQ-1:0] w_win_gnt;
  logic [OW-1:0]   w_win_idx;
  logic            w_win_valid;
  logic [SW-1:0]   w_sel_sprite;
  logic [RW-1:0]   w_sel_row;

  assign w_col_last = (r_col == COL_LAST);

  // r_owner doubles as the round-robin pointer; its reset value makes req[0] first.
  rr_arbiter #(.NREQ(NREQ), .OW(OW)) u_rr_arbiter (
    .i_req        (bus.req),
    .i_en         (w_arb_en),
    .i_last_owner (r_owner),
    .o_gnt        (w_win_gnt),
    .o_idx        (w_win_idx),
    .o_valid      (w_win_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state: a burst continues straight into the next one on a re-grant.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_win_valid) w_next_state = ST_BURST;
        else             w_next_state = ST_IDLE;
      end
      ST_BURST: begin
        if (w_col_last) w_next_state = w_win_valid ? ST_BURST : ST_IDLE;
        else            w_next_state = ST_BURST;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State outputs: arbitrate when idle or while the last column is on the bus.
  always_comb begin
    w_busy   = 1'b0;
    w_arb_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy   = 1'b0;
        w_arb_en = 1'b1;
      end
      ST_BURST: begin
        w_busy   = 1'b1;
        w_arb_en = w_col_last;
      end
      default: begin
        w_busy   = 1'b0;
        w_arb_en = 1'b0;
      end
    endcase
  end

  // Mux the winner's sprite/row slices with the one-hot grant.
  always_comb begin
    w_sel_sprite = '0;
    w_sel_row    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sel_sprite = w_sel_sprite | (bus.req_sprite[i*SW +: SW] & {SW{w_win_gnt[i]}});
      w_sel_row    = w_sel_row    | (bus.req_row[i*RW +: RW]    & {RW{w_win_gnt[i]}});
    end
  end

  // Address side: latch sprite/row/owner on grant, else step the column.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gnt    <= '0;
      r_sprite <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_owner  <= OWNER_INIT;
    end else begin
      r_gnt <= w_win_gnt;
      if (w_win_valid) begin
        r_sprite <= w_sel_sprite;
        r_row    <= w_sel_row;
        r_col    <= '0;
        r_owner  <= w_win_idx;
      end else if (w_busy && !w_col_last) begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Pixel side lags the address by one cycle to line up with rom_pixel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
      r_pix_col   <= '0;
      r_pix_owner <= '0;
    end else begin
      r_pix_valid <= w_busy;
      r_pix_last  <= w_busy & w_col_last;
      if (w_busy) begin
        r_pix_col   <= r_col;
        r_pix_owner <= r_owner;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rom_add   = {r_sprite, r_row, r_col};
  assign bus.pix_valid = r_pix_valid;
  assign bus.pix_data  = r_pix_valid ? bus.rom_pixel : {PW{1'b0}};
  assign bus.pix_col   = r_pix_col;
  assign bus.pix_owner = r_pix_owner;
  assign bus.pix_last  = r_pix_last;
  assign bus.busy      = w_busy;

endmodule

// File: doc/sprite_rom_scheduler.md
Name: sprite_rom_scheduler

Overview:
Shares the single-port sprite bitmap ROM (4 sprites × 16×16 pixels × 4 bpp, 1024 words, 1-cycle registered read) between several sprite engines (pac-man plus ghosts). Each engine requests one full 16-pixel sprite row. The scheduler arbitrates round-robin at row granularity and drives the ROM address. It then streams the returned pixels back, tagged with owner and column. It sits between the per-sprite line renderers and the ROM instance.

Parameters:
NREQ, 4, number of requesters (2..8)
NSPRITES, 4, sprites stored in ROM (power of 2)
WIDTH, 16, sprite width in pixels (power of 2)
HEIGHT, 16, sprite height in rows (power of 2)
PW, 4, pixel width in bits

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
req  in  NREQ  level request per engine, one row each
req_sprite  in  NREQ*log2(NSPRITES)  sprite index per requester (slice i)
req_row  in  NREQ*log2(HEIGHT)  row index per requester (slice i)
gnt  out  NREQ  one-hot, 1-cycle pulse: request accepted, sprite/row latched
rom_add  out  log2(NSPRITES*WIDTH*HEIGHT)  ROM address
rom_pixel  in  PW  ROM data, valid 1 cycle after rom_add
pix_valid  out  1  pix_* qualifies a pixel
pix_data  out  PW  pixel value (rom_pixel passed through)
pix_col  out  log2(WIDTH)  column of pix_data
pix_owner  out  log2(NREQ)  requester index owning pix_data
pix_last  out  1  high with column WIDTH-1
busy  out  1  burst in progress

Behaviour:
- Reset (async, any time including mid-burst): state IDLE; gnt=0; rom_add=0; pix_valid=0; pix_data=0; pix_col=0; pix_owner=0; pix_last=0; busy=0; RR pointer gives req[0] highest priority. No partial burst resumes after reset.
- Address packing is {sprite, row, col} with col in the LSBs.
- States:
  - IDLE: rom_add is held.
  - BURST: col counter runs 0..WIDTH-1.
- Arbitration point: any cycle in IDLE, or the BURST cycle where col==WIDTH-1 is issued.
  - If any req is high, the round-robin winner is chosen: first requester after the last owner, wrapping modulo NREQ.
  - On the next edge: gnt[winner] pulses for 1 cycle, sprite/row are latched, owner is set, col=0, state is BURST.
  - Otherwise the next state is IDLE.
- Timing: req seen at edge t → gnt high and rom_add=col 0 during cycle t+1 → rom_add covers cols 0..15 in cycles t+1..t+16 → pix_valid high cycles t+2..t+17, pix_col 0..15, pix_last at t+17.
- Back-to-back requests give zero bubble: the next burst's col 0 address immediately follows col 15. pix_valid then stays continuously high and pix_owner changes on the col-0 pixel.
- pix_* are a registered copy of the address-side owner/col, delayed 1 cycle to align with rom_pixel. pix_data is rom_pixel combinationally.
- busy=1 in BURST.
- Requester contract: deassert req the cycle after gnt unless another row is wanted. A req held high is treated as a new request. Round-robin guarantees each requester waits at most NREQ-1 bursts.
- req dropping mid-burst does not abort the burst; all WIDTH pixels are delivered.
- req_sprite/req_row are sampled only at the grant edge; later changes have no effect on the current burst.
- The RR pointer updates only on grant.
- Col counter wraps WIDTH-1→0 only via re-grant. No wrap into the next row or sprite.
- No stall or backpressure: consumers must accept 1 pixel/cycle.

Decomposition:
- Shared package sprite_pkg holds:
  - constants SPR_W=16, SPR_H=16, SPR_N=4, SPR_PW=4;
  - derived widths COL_W, ROW_W, SPR_IDX_W, ROM_AW;
  - function spr_addr(sprite,row,col), reused by the renderers.
- One sub-module: rr_arbiter, NREQ-wide. It takes req, a 1-cycle enable and last_owner. It outputs one-hot gnt plus an encoded index; this logic is purely combinational.
- The scheduler holds the FSM, col counter and output pipeline register.

Test Plan:
- Single request: after reset, req[2]=1 with sprite 1, row 5 for one cycle → gnt[2] the next cycle; rom_add = 0x150..0x15F in consecutive cycles; 16 pix_valid pixels with owner 2, cols 0..15, pix_last on col 15; then busy=0.
- Contention: req=4'b1111 held continuously → grant order 0,1,2,3,0; pix_valid continuously high from first pixel on; owner changes exactly at each col-0 pixel.
- Back-to-back same requester: req[0] high for 40 cycles, no other requester → three consecutive bursts with no gap in pix_valid; rom_add wraps from col 15 to col 0 of the re-latched row.
- Latch isolation: req_row changes 5→9 mid-burst → current burst stays at row 5; the next grant uses row 9.
- Reset mid-burst: rstn low while col=7 → pix_valid, busy, gnt and rom_add go 0 asynchronously; after release with req[3] pending, req[3] is granted (pointer back to 0, no pending higher-priority requester).
- Idle hold: no req for 20 cycles → gnt=0, pix_valid=0, rom_add unchanged from the last issued value.
